// File: rtl/pmt_timebin_latch.sv
// pmt_timebin_latch: multi-channel time-bin sequencer for the PMT counting path.
// Splits clk into programmable bins. At each bin boundary it snapshots CH
// external counters, clears them and queues {snapshot, bin index} in a
// first-word-fall-through FIFO that a valid/ready stream drains.
// Build option: define TIMEBIN_DROP_OLDEST_EN so that a push into a full FIFO
// evicts the oldest entry. By default the new snapshot is discarded.
module pmt_timebin_latch #(
  parameter int CH    = 4,
  parameter int CW    = 8,
  parameter int BIN_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [BIN_W-1:0]             bin_len,
  input  logic [15:0]                  n_bins,
  input  logic [CH*CW-1:0]             cnt_in,
  output logic                         cnt_clr,
  output logic                         busy,
  output logic                         done,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CH*CW-1:0]             m_data,
  output logic [15:0]                  m_idx,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic                         led
);

  localparam int DW = CH * CW;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [BIN_W-1:0]          bin_len_q, bin_len_d;
  logic [15:0]               n_bins_q, n_bins_d;
  logic [BIN_W-1:0]          timer_q, timer_d;
  logic [15:0]               idx_q, idx_d;
  logic                      cnt_clr_q, cnt_clr_d;
  logic                      done_q, done_d;
  logic                      led_q, led_d;
  logic                      overflow_q, overflow_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic [DEPTH-1:0][DW-1:0]  data_mem_q;
  logic [DEPTH-1:0][15:0]    idx_mem_q;

  logic push, pop, full, wr_en, clr_ovf;

  // Sequencer: start/stop handling, bin timer, boundary detection
  always_comb begin
    state_d   = state_q;
    bin_len_d = bin_len_q;
    n_bins_d  = n_bins_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    led_d     = led_q;
    cnt_clr_d = 1'b0;
    done_d    = 1'b0;
    push      = 1'b0;
    clr_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A 1-cycle bin would leave no cycle between clear pulses
          bin_len_d = (bin_len < BIN_W'(2)) ? BIN_W'(2) : bin_len;
          n_bins_d  = n_bins;
          timer_d   = '0;
          idx_d     = '0;
          clr_ovf   = 1'b1;
          cnt_clr_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort wins over a coincident boundary: partial bin is dropped
          state_d = IDLE;
        end else if (timer_q == bin_len_q - BIN_W'(1)) begin
          push    = 1'b1;
          led_d   = ~led_q;
          timer_d = '0;
          // Index advances even if the FIFO drops this bin, so gaps show loss
          idx_d   = idx_q + 16'd1;
          if (n_bins_q != 16'd0 && idx_q == n_bins_q - 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_clr_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + BIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot FIFO: pointer/level bookkeeping and overflow policy
  always_comb begin
    pop        = m_valid & m_ready;
    full       = (level_q == LW'(DEPTH));
    wr_en      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = clr_ovf ? 1'b0 : overflow_q;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      if (!full || pop) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef TIMEBIN_DROP_OLDEST_EN
        // Evict the head and store the new snapshot at the tail
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
`endif
      end
    end
    // Level moves only on a net push or a net pop; eviction keeps it at DEPTH
    if (pop && !wr_en)
      level_d = level_q - LW'(1);
    else if (wr_en && !pop && !full)
      level_d = level_q + LW'(1);
  end

  // State, counters, FIFO storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_len_q  <= '0;
      n_bins_q   <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      cnt_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_mem_q <= '0;
      idx_mem_q  <= '0;
    end else begin
      state_q    <= state_d;
      bin_len_q  <= bin_len_d;
      n_bins_q   <= n_bins_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      cnt_clr_q  <= cnt_clr_d;
      done_q     <= done_d;
      led_q      <= led_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      if (wr_en) begin
        data_mem_q[wr_ptr_q] <= cnt_in;
        idx_mem_q[wr_ptr_q]  <= idx_q;
      end
    end
  end

  assign busy       = (state_q == RUN);
  assign cnt_clr    = cnt_clr_q;
  assign done       = done_q;
  assign led        = led_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
  assign m_valid    = (level_q != '0);
  assign m_data     = data_mem_q[rd_ptr_q];
  assign m_idx      = idx_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_pmt_timebin_latch.sv
// Bench for pmt_timebin_latch: a queue-based reference model runs every cycle
// and is compared against all outputs, plus a vector table of finite runs and
// hand-written sequences for overflow, boundary-stop and mid-run reset.
module tb_pmt_timebin_latch;
  localparam int CH = 4, CW = 8, BIN_W = 32, DEPTH = 4;
  localparam int DW = CH * CW;
  localparam int LW = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset, start, stop, m_ready;
  logic [BIN_W-1:0]  bin_len;
  logic [15:0]       n_bins;
  logic [DW-1:0]     cnt_in;
  logic              cnt_clr, busy, done, m_valid, overflow, led;
  logic [DW-1:0]     m_data;
  logic [15:0]       m_idx;
  logic [LW-1:0]     fifo_level;

  pmt_timebin_latch #(.CH(CH), .CW(CW), .BIN_W(BIN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bin_len(bin_len),
    .n_bins(n_bins), .cnt_in(cnt_in), .cnt_clr(cnt_clr), .busy(busy),
    .done(done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .fifo_level(fifo_level), .overflow(overflow), .led(led)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model state, described in terms of the acquisition rules
  typedef struct { logic [DW-1:0] d; int i; } ent_t;
  ent_t q[$];
  bit   r_run, r_ovf, r_led, r_clr, r_done;
  int   r_bl, r_nb, r_t, r_idx;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic model_step();
    bit pop, push, last;
    ent_t e;
    e.d = '0; e.i = 0;
    if (reset) begin
      r_run = 0; r_ovf = 0; r_led = 0; r_clr = 0; r_done = 0;
      r_t = 0; r_idx = 0; q.delete();
      return;
    end
    pop  = (q.size() != 0) && m_ready;
    push = 0; r_clr = 0; r_done = 0;
    if (!r_run) begin
      if (start) begin
        r_bl  = (bin_len < 2) ? 2 : int'(bin_len);
        r_nb  = int'(n_bins);
        r_t   = 0; r_idx = 0; r_ovf = 0; r_clr = 1; r_run = 1;
      end
    end else if (stop) begin
      r_run = 0;
    end else if (r_t == r_bl - 1) begin
      e.d = cnt_in; e.i = r_idx; push = 1;
      r_led = !r_led; r_t = 0;
      last  = (r_nb != 0) && (r_idx == r_nb - 1);
      r_idx = (r_idx + 1) % 65536;
      if (last) begin r_done = 1; r_run = 0; end
      else r_clr = 1;
    end else begin
      r_t++;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        r_ovf = 1;
`ifdef TIMEBIN_DROP_OLDEST_EN
        void'(q.pop_front());
        q.push_back(e);
`endif
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, r_run);
    chk("cnt_clr", cnt_clr, r_clr);
    chk("done", done, r_done);
    chk("led", led, r_led);
    chk("overflow", overflow, r_ovf);
    chk("m_valid", m_valid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    if (q.size() != 0) begin
      chk("m_data", m_data, q[0].d);
      chk("m_idx", m_idx, q[0].i);
    end
  endtask

  // One clock: model and DUT both see the inputs at the edge, compare after
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  task automatic run_start(input logic [BIN_W-1:0] bl, input logic [15:0] nb);
    bin_len = bl; n_bins = nb; start = 1; step(); start = 0;
  endtask

  typedef struct {
    logic [BIN_W-1:0] bl;
    logic [15:0]      nb;
    logic [DW-1:0]    cnt;
    int               exp_cyc;  // edges from start to done
  } vec_t;
  vec_t tbl[6];

  int k, npop, last_idx;
  bit got_done;
  logic [DW-1:0] bad_data;

  initial begin
    tbl[0] = '{32'd10, 16'd3, 32'h04030201, 30};
    tbl[1] = '{32'd0,  16'd2, 32'hdeadbeef, 4};
    tbl[2] = '{32'd1,  16'd3, 32'h00ff00ff, 6};
    tbl[3] = '{32'd3,  16'd1, 32'h12345678, 3};
    tbl[4] = '{32'd2,  16'd5, 32'hcafef00d, 10};
    tbl[5] = '{32'd7,  16'd2, 32'h80000001, 14};

    reset = 1; start = 0; stop = 0; m_ready = 0;
    bin_len = '0; n_bins = '0; cnt_in = '0;
    steps(2);
    reset = 0;
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);

    // Finite runs with the sink always ready
    for (int v = 0; v < 6; v++) begin
      do_reset();
      m_ready = 1; cnt_in = tbl[v].cnt;
      run_start(tbl[v].bl, tbl[v].nb);
      k = 0; got_done = 0; npop = 0; last_idx = -1; bad_data = '0;
      while (!got_done && k < 200) begin
        step(); k++;
        if (m_valid) begin npop++; last_idx = m_idx; bad_data |= m_data ^ tbl[v].cnt; end
        if (done) got_done = 1;
      end
      chk("tbl_done_cycle", k, tbl[v].exp_cyc);
      steps(3);
      chk("tbl_entries", npop, tbl[v].nb);
      chk("tbl_last_idx", last_idx, tbl[v].nb - 1);
      chk("tbl_data", bad_data, 0);
    end

    // Five bins into a 4-deep FIFO with no reader
    do_reset();
    m_ready = 0; cnt_in = 32'h11223344;
    run_start(5, 0);
    steps(25);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
`ifdef TIMEBIN_DROP_OLDEST_EN
    chk("ovf_head_idx", m_idx, 1);
`else
    chk("ovf_head_idx", m_idx, 0);
`endif

    // Full FIFO, pop coincides with the boundary: no overflow
    do_reset();
    run_start(5, 0);
    steps(20);
    chk("full_level", fifo_level, 4);
    chk("full_ovf", overflow, 0);
    steps(4);
    m_ready = 1; step(); m_ready = 0;
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", m_idx, 1);
    m_ready = 1; steps(3); m_ready = 0;
    chk("pp_tail", m_idx, 4);

    // Stop on a boundary, then restart
    do_reset();
    run_start(2, 0);
    steps(10);
    chk("stop_pre_ovf", overflow, 1);
    m_ready = 1; step(); m_ready = 0;
    stop = 1; step(); stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_clr", cnt_clr, 0);
    chk("stop_level", fifo_level, 3);
    run_start(2, 0);
    chk("restart_ovf", overflow, 0);
    chk("restart_clr", cnt_clr, 1);
    steps(2);
    m_ready = 1; steps(3); m_ready = 0;
    chk("restart_idx", m_idx, 0);

    // Reset in the middle of a bin with two entries queued
    do_reset();
    run_start(10, 0);
    steps(23);
    chk("mid_level", fifo_level, 2);
    reset = 1; step(); reset = 0;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_led", led, 0);

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      bin_len = BIN_W'($urandom_range(0, 6));
      n_bins  = 16'($urandom_range(0, 5));
      cnt_in  = $urandom;
      m_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
